// File: rtl/pace_pkg.sv
// Shared types and helpers for the pace engine: run/freeze state encoding,
// level width and the floored period decrement.
package pace_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } pace_state_t;

    localparam int LW   = 4;
    // Widest period the helper handles; channels zero-extend into it.
    localparam int PMAX = 32;

    // Next period after one acceleration event, never going below the floor.
    // The compare runs one bit wider so min_p + dec cannot wrap.
    function automatic logic [PMAX-1:0] sat_sub(
        input logic [PMAX-1:0] period,
        input logic [PMAX-1:0] dec,
        input logic [PMAX-1:0] min_p
    );
        logic [PMAX:0] floor_sum;
        floor_sum = {1'b0, min_p} + {1'b0, dec};
        if ({1'b0, period} < floor_sum) begin
            return min_p;
        end
        return period - dec;
    endfunction

endpackage

// File: rtl/pace_ctrl_if.sv
// Control/status bundle between the start/debounce logic and the pace engine.
// The boost input exists only when PACE_BOOST_EN is defined.
//
// Handshake: there is no valid/ready pair here; start and halt are levels
// sampled every cycle, restart is a one-cycle pulse, and tick/accel_pulse
// are registered one-cycle strobes that the consumer must take when seen.
interface pace_ctrl_if
    import pace_pkg::*;
#(
    parameter int NCH     = 3,
    parameter int SCORE_W = 6
);
    logic               start;
    logic               halt;
    logic               restart;
`ifdef PACE_BOOST_EN
    logic               boost;
`endif
    logic [NCH-1:0]     tick;
    logic               accel_pulse;
    logic [LW-1:0]      level;
    logic [SCORE_W-1:0] score;
    logic               score_sat;
    logic               running;
    pace_state_t        state;

    modport master (
        output start, halt, restart,
`ifdef PACE_BOOST_EN
        output boost,
`endif
        input  tick, accel_pulse, level, score, score_sat, running, state
    );

    modport slave (
        input  start, halt, restart,
`ifdef PACE_BOOST_EN
        input  boost,
`endif
        output tick, accel_pulse, level, score, score_sat, running, state
    );

endinterface

// File: rtl/pace_channel.sv
// One tick channel: period register shortened on acceleration events,
// a RUN-only counter, and a registered one-cycle tick strobe.
module pace_channel
    import pace_pkg::*;
#(
    parameter int            PW   = 26,
    parameter logic [PW-1:0] INIT = PW'(10),
    parameter logic [PW-1:0] DEC  = PW'(1),
    parameter logic [PW-1:0] MIN  = PW'(2)
)(
    input  logic clk,
    input  logic clear,
    input  logic run,
    input  logic accel,
    input  logic boost,
    output logic tick
);

    logic [PW-1:0] period;
    logic [PW-1:0] cnt;
    logic [PW-1:0] half;
    logic [PW-1:0] thr;

    // Boost halves the effective threshold but never below 2.
    always_comb begin
        half = period >> 1;
        thr  = period;
        if (boost) begin
            thr = (half < PW'(2)) ? PW'(2) : half;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            period <= INIT;
            cnt    <= '0;
            tick   <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (run) begin
                // >= rather than == so a period shrinking under cnt still wraps.
                if (cnt >= thr - PW'(1)) begin
                    cnt  <= '0;
                    tick <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                if (accel) begin
                    period <= PW'(sat_sub(PMAX'(period), PMAX'(DEC), PMAX'(MIN)));
                end
            end
        end
    end

endmodule

// File: rtl/pace_ctrl.sv
// Game-pace engine: run/freeze FSM, NCH tick channels that speed up on each
// acceleration event, saturating level and score. Optional PACE_BOOST_EN.
module pace_ctrl
    import pace_pkg::*;
#(
    parameter int                NCH          = 3,
    parameter int                PW           = 26,
    parameter logic [NCH*PW-1:0] INIT_PERIODS = {26'd25_000_000, 26'd2_500_000, 26'd5_000_000},
    parameter logic [NCH*PW-1:0] DEC_STEPS    = {26'd1_250_000, 26'd125_000, 26'd250_000},
    parameter logic [NCH*PW-1:0] MIN_PERIODS  = {26'd5_000_000, 26'd500_000, 26'd1_000_000},
    parameter int                ACCEL_PERIOD = 100_000_000,
    parameter int                MAX_LEVEL    = 15,
    parameter int                SCORE_DIV    = 50_000_000,
    parameter int                SCORE_W      = 6
)(
    input  logic       clk,
    input  logic       reset,
    pace_ctrl_if.slave bus
);

    localparam int AW  = (ACCEL_PERIOD > 1) ? $clog2(ACCEL_PERIOD) : 1;
    localparam int SDW = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
    localparam logic [SCORE_W-1:0] SCORE_ONES = '1;

    pace_state_t        state;
    pace_state_t        state_next;
    logic               run_en;
    logic               clear;
    logic               boost_en;
    logic               accel_evt;
    logic               score_evt;
    logic [AW-1:0]      acc_cnt;
    logic [SDW-1:0]     sdiv_cnt;
    logic               accel_pulse;
    logic [LW-1:0]      level;
    logic [SCORE_W-1:0] score;
    logic               score_sat;
    logic [NCH-1:0]     tick_v;

    // Restart reloads exactly what reset loads.
    assign clear = reset | bus.restart;

    always_ff @(posedge clk) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start && !bus.halt) state_next = RUN;
            RUN:     if (bus.halt)               state_next = FROZEN;
            FROZEN:  if (!bus.halt)              state_next = RUN;
            default:                             state_next = IDLE;
        endcase
    end

    // The cycle that leaves RUN still counts, so a wrap on a halt cycle completes.
    always_comb begin
        run_en = (state == RUN);
    end

`ifdef PACE_BOOST_EN
    assign boost_en = bus.boost & run_en;
`else
    assign boost_en = 1'b0;
`endif

    assign accel_evt = run_en && (acc_cnt == AW'(ACCEL_PERIOD - 1));
    assign score_evt = run_en && (sdiv_cnt == SDW'(SCORE_DIV - 1));

    always_ff @(posedge clk) begin
        if (clear) begin
            acc_cnt     <= '0;
            sdiv_cnt    <= '0;
            accel_pulse <= 1'b0;
            level       <= '0;
            score       <= '0;
            score_sat   <= 1'b0;
        end else begin
            accel_pulse <= accel_evt;
            if (run_en) begin
                acc_cnt  <= accel_evt ? '0 : acc_cnt + 1'b1;
                sdiv_cnt <= score_evt ? '0 : sdiv_cnt + 1'b1;
            end
            if (accel_evt && (level != LW'(MAX_LEVEL))) begin
                level <= level + 1'b1;
            end
            if (score_evt && !score_sat) begin
                score     <= score + 1'b1;
                score_sat <= (score == SCORE_ONES - 1'b1);
            end
        end
    end

    // A tick on the acceleration cycle still sees the old period inside the channel.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        pace_channel #(
            .PW   (PW),
            .INIT (INIT_PERIODS[i*PW +: PW]),
            .DEC  (DEC_STEPS[i*PW +: PW]),
            .MIN  (MIN_PERIODS[i*PW +: PW])
        ) u_ch (
            .clk   (clk),
            .clear (clear),
            .run   (run_en),
            .accel (accel_evt),
            .boost (boost_en),
            .tick  (tick_v[i])
        );
    end

    assign bus.tick        = tick_v;
    assign bus.accel_pulse = accel_pulse;
    assign bus.level       = level;
    assign bus.score       = score;
    assign bus.score_sat   = score_sat;
    assign bus.running     = run_en;
    assign bus.state       = state;

endmodule
